// File: rtl/mgmt_bus_arbiter_pkg.sv
// mgmt_bus_arbiter_pkg: shared states and constants for the mgmt bus arbiter
package mgmt_bus_arbiter_pkg;
  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_RSP  = 2'd2
  } arb_state_t;
  localparam logic [31:0] MGMT_ERR_DATA = 32'hDEAD_BEEF;
endpackage

// File: rtl/mgmt_bus_arbiter_rr_pick.sv
// mgmt_bus_arbiter_rr_pick: combinational round-robin picker, first requester after last wins
module mgmt_bus_arbiter_rr_pick #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          valid,
  output logic [IW-1:0] idx
);
  assign valid = |req;
  // scan from the farthest candidate back to last+1 so the nearest one wins
  always_comb begin
    idx = '0;
    for (int k = N; k >= 1; k--) if (req[IW'((int'(last) + k) % N)]) idx = IW'((int'(last) + k) % N);
  end
endmodule

// File: rtl/mgmt_bus_arbiter.sv
// mgmt_bus_arbiter: round-robin sharing of the mgmt slave port with a completion watchdog
module mgmt_bus_arbiter
  import mgmt_bus_arbiter_pkg::*;
#(
  parameter int          NUM_REQ  = 2,
  parameter int          TIMEOUT  = 255,
  parameter int          CNT_W    = 8,
  parameter logic [31:0] ERR_DATA = MGMT_ERR_DATA
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic [NUM_REQ-1:0]    m_req,
  input  logic [NUM_REQ*32-1:0] m_adr,
  input  logic [NUM_REQ-1:0]    m_rwn,
  input  logic [NUM_REQ*2-1:0]  m_wen,
  input  logic [NUM_REQ*32-1:0] m_txd,
  output logic [NUM_REQ-1:0]    m_ack,
  output logic [NUM_REQ-1:0]    m_rxe,
  output logic [31:0]           m_rxd,
  output logic [NUM_REQ-1:0]    m_err,
  output logic                  s_req,
  output logic [31:0]           s_adr,
  output logic                  s_rwn,
  output logic [1:0]            s_wen,
  output logic [31:0]           s_txd,
  input  logic                  s_ack,
  input  logic                  s_rxe,
  input  logic [31:0]           s_rxd
);
  localparam int IW = $clog2(NUM_REQ);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  arb_state_t state, state_nxt;
  logic [IW-1:0] grant, last, win;
  logic win_vld, strobe, to;
  logic [CNT_W-1:0] cnt;
  logic [NUM_REQ-1:0] gsel;
  mgmt_bus_arbiter_rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req   (m_req),
    .last  (last),
    .valid (win_vld),
    .idx   (win)
  );
  assign gsel = NUM_REQ'(1) << grant;
  // state register; reset aborts any transaction in flight
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= ARB_IDLE;
    else state <= state_nxt;
  end
  // next state, watchdog expiry and master-side strobes, all gated by state
  always_comb begin
    strobe    = (state == ARB_REQ) ? s_ack : s_rxe;
    to        = (TIMEOUT != 0) && (state != ARB_IDLE) && !strobe && (cnt == TO_LAST);
    state_nxt = (state == ARB_IDLE) ? (win_vld ? ARB_REQ : ARB_IDLE)
              : (state == ARB_REQ)  ? ((to || (s_ack && (!s_rwn || s_rxe))) ? ARB_IDLE : (s_ack ? ARB_RSP : ARB_REQ))
              : ((s_rxe || to) ? ARB_IDLE : ARB_RSP);
    m_ack     = (state == ARB_REQ && (s_ack || to)) ? gsel : '0;
    m_rxe     = ((state == ARB_REQ && s_rwn && ((s_ack && s_rxe) || to)) || (state == ARB_RSP && (s_rxe || to))) ? gsel : '0;
    m_err     = to ? gsel : '0;
    m_rxd     = to ? ERR_DATA : s_rxd;
  end
  // grant bookkeeping, latched slave request and watchdog counter
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      s_req <= 1'b0;
      s_adr <= '0;
      s_rwn <= 1'b1;
      s_wen <= '0;
      s_txd <= '0;
      grant <= '0;
      last  <= IW'(NUM_REQ - 1);
      cnt   <= '0;
    end else begin
      if (state == ARB_IDLE && win_vld) begin
        grant <= win;
        last  <= win;
        s_adr <= m_adr[{win, 5'd0} +: 32];
        s_txd <= m_txd[{win, 5'd0} +: 32];
        s_wen <= m_wen[{win, 1'b0} +: 2];
        s_rwn <= m_rwn[win];
        s_req <= 1'b1;
      end
      if (state == ARB_REQ && (s_ack || to)) s_req <= 1'b0;
      cnt <= (state != ARB_IDLE && state_nxt == state) ? cnt + 1'b1 : '0;
    end
  end
endmodule

// File: tb/tb_mgmt_bus_arbiter.sv
// tb_mgmt_bus_arbiter: directed checks of arbitration, reads, timeout and reset abort
module tb_mgmt_bus_arbiter;
  localparam logic [31:0] A0 = 32'h0000_0100;
  localparam logic [31:0] A1 = 32'h0000_0104;
  logic sys_clk = 1'b0;
  logic sys_rst_n;
  logic [1:0] m_req, m_rwn, m_ack, m_rxe, m_err;
  logic [63:0] m_adr, m_txd;
  logic [3:0] m_wen;
  logic [31:0] m_rxd, s_adr, s_txd, s_rxd;
  logic s_req, s_rwn, s_ack, s_rxe;
  logic [1:0] s_wen;
  int n_chk = 0;
  int n_fail = 0;
  always #5 sys_clk = ~sys_clk;
  mgmt_bus_arbiter #(.NUM_REQ(2), .TIMEOUT(8), .CNT_W(8)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .m_req     (m_req),
    .m_adr     (m_adr),
    .m_rwn     (m_rwn),
    .m_wen     (m_wen),
    .m_txd     (m_txd),
    .m_ack     (m_ack),
    .m_rxe     (m_rxe),
    .m_rxd     (m_rxd),
    .m_err     (m_err),
    .s_req     (s_req),
    .s_adr     (s_adr),
    .s_rwn     (s_rwn),
    .s_wen     (s_wen),
    .s_txd     (s_txd),
    .s_ack     (s_ack),
    .s_rxe     (s_rxe),
    .s_rxd     (s_rxd)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic nxt;
    @(posedge sys_clk);
    #1;
  endtask
  task automatic smp;
    @(negedge sys_clk);
  endtask
  initial begin
    sys_rst_n = 1'b0;
    m_req = 2'b11;
    m_rwn = 2'b00;
    m_adr = {A1, A0};
    m_wen = 4'b1111;
    m_txd = {32'h0000_00B1, 32'h0000_00A0};
    s_ack = 1'b0;
    s_rxe = 1'b0;
    s_rxd = '0;
    smp;
    smp;
    chk("rst_s_req", s_req, 0);
    chk("rst_m_ack", m_ack, 0);
    chk("rst_s_rwn", s_rwn, 1);
    chk("rst_s_adr", s_adr, 0);
    nxt; sys_rst_n = 1'b1; smp;
    chk("rel_s_req", s_req, 0);
    nxt; smp;
    chk("first_s_req", s_req, 1);
    chk("first_s_txd", s_txd, 32'hA0);
    chk("first_s_wen", s_wen, 2'b11);
    for (int g = 0; g < 4; g++) begin
      chk($sformatf("rr%0d_s_adr", g), s_adr, g[0] ? A1 : A0);
      chk($sformatf("rr%0d_s_req", g), s_req, 1);
      chk($sformatf("rr%0d_ack_wait", g), m_ack, 0);
      nxt; s_ack = 1'b1; smp;
      chk($sformatf("rr%0d_m_ack", g), m_ack, g[0] ? 2'b10 : 2'b01);
      nxt; s_ack = 1'b0; if (g == 3) m_req = 2'b00; smp;
      chk($sformatf("rr%0d_ack_end", g), m_ack, 0);
      chk($sformatf("rr%0d_s_req_low", g), s_req, 0);
      nxt; smp;
    end
    chk("rr_stop", s_req, 0);
    nxt; m_req = 2'b10; m_rwn = 2'b10; smp;
    nxt; smp;
    chk("rd_s_req", s_req, 1);
    chk("rd_s_rwn", s_rwn, 1);
    chk("rd_s_adr", s_adr, A1);
    nxt; smp;
    nxt; s_ack = 1'b1; smp;
    chk("rd_m_ack", m_ack, 2'b10);
    chk("rd_rxe_early", m_rxe, 0);
    nxt; s_ack = 1'b0; m_req = 2'b00; smp;
    chk("rd_s_req_low", s_req, 0);
    nxt; smp;
    chk("rd_rxe_wait", m_rxe, 0);
    nxt; s_rxe = 1'b1; s_rxd = 32'h1234_5678; smp;
    chk("rd_m_rxe", m_rxe, 2'b10);
    chk("rd_m_rxd", m_rxd, 32'h1234_5678);
    chk("rd_m_err", m_err, 0);
    nxt; smp;
    chk("rd_idle_rxe", m_rxe, 0);
    nxt; s_rxe = 1'b0; m_req = 2'b11; m_rwn = 2'b01; s_rxd = 32'hCAFE_F00D; smp;
    nxt; s_ack = 1'b1; s_rxe = 1'b1; smp;
    chk("same_s_adr", s_adr, A0);
    chk("same_m_ack", m_ack, 2'b01);
    chk("same_m_rxe", m_rxe, 2'b01);
    chk("same_m_rxd", m_rxd, 32'hCAFE_F00D);
    nxt; s_ack = 1'b0; m_req = 2'b10; smp;
    chk("same_no_rsp", m_rxe, 0);
    chk("same_s_req_low", s_req, 0);
    nxt; s_rxe = 1'b0; smp;
    chk("next_s_req", s_req, 1);
    chk("next_s_adr", s_adr, A1);
    chk("next_s_rwn", s_rwn, 0);
    nxt; s_ack = 1'b1; smp;
    chk("next_m_ack", m_ack, 2'b10);
    nxt; s_ack = 1'b0; m_req = 2'b00; smp;
    nxt; m_req = 2'b01; s_rxd = 32'h1111_1111; smp;
    nxt; smp;
    chk("to_s_req", s_req, 1);
    chk("to_s_adr", s_adr, A0);
    repeat (6) begin nxt; smp; end
    chk("to_pre_ack", m_ack, 0);
    chk("to_pre_err", m_err, 0);
    nxt; smp;
    chk("to_m_ack", m_ack, 2'b01);
    chk("to_m_rxe", m_rxe, 2'b01);
    chk("to_m_err", m_err, 2'b01);
    chk("to_m_rxd", m_rxd, 32'hDEAD_BEEF);
    nxt; m_req = 2'b00; smp;
    chk("to_s_req_low", s_req, 0);
    chk("to_err_pulse", m_err, 0);
    chk("to_rxd_restore", m_rxd, 32'h1111_1111);
    nxt; s_ack = 1'b1; s_rxe = 1'b1; smp;
    chk("late_m_ack", m_ack, 0);
    chk("late_m_rxe", m_rxe, 0);
    chk("late_m_err", m_err, 0);
    nxt; s_ack = 1'b0; s_rxe = 1'b0; smp;
    nxt; m_req = 2'b01; smp;
    nxt; s_ack = 1'b1; smp;
    chk("abt_m_ack", m_ack, 2'b01);
    nxt; s_ack = 1'b0; m_req = 2'b00; smp;
    chk("abt_rsp_wait", m_rxe, 0);
    nxt; sys_rst_n = 1'b0; s_rxe = 1'b1; m_req = 2'b11; smp;
    chk("abt_s_req", s_req, 0);
    chk("abt_m_rxe", m_rxe, 0);
    chk("abt_m_ack", m_ack, 0);
    nxt; sys_rst_n = 1'b1; s_rxe = 1'b0; smp;
    chk("abt_rel_s_req", s_req, 0);
    nxt; smp;
    chk("post_s_req", s_req, 1);
    chk("post_s_adr", s_adr, A0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
